lock_controller: RTL and testbench

- Security-lock sequencer that sits upstream of the HEX/LED display driver.
- Takes a code from the slide switches and a debounced enter key, and tracks failed attempts.
- Enforces a timed lockout with a blinking alarm LED and auto-relocks after a timeout.
- Drives the display driver's 32-bit trigger word (bit1 = unlocked, bit0 = LED on).

---
 rtl/lock_controller.sv | 184 ++++++++++++++++++
 tb/tb_lock_controller.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lock_controller.sv
// Security-lock sequencer feeding the HEX/LED display driver trigger word.
// Latency: every output is registered and changes on the same edge as the state.
// Backpressure: none; enter is edge-detected internally, so holding it yields a single event.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset (synchronous release upstream)
//   sw[CODE_W-1:0]        candidate code, or new code when set_code qualifies enter
//   enter                 debounced/synchronised enter key (level)
//   set_code              with an enter event while unlocked, program sw as the new code
//   lock_req              manual lock request (level)
//   trigger[31:0]         [1]=unlocked, [0]=LED, [31:2]=0
//   unlocked, alarm       state is UNLOCKED / LOCKOUT
//   fail_cnt[2:0]         consecutive wrong entries so far
// Build option: define LOCK_AUTO_RELOCK_EN to add the auto-relock timer in UNLOCKED.
module lock_controller #(
    parameter int unsigned          CODE_W         = 10,
    parameter logic [CODE_W-1:0]    DEFAULT_CODE   = CODE_W'(10'h2A5),
    parameter int unsigned          MAX_TRIES      = 3,
    parameter int unsigned          LOCKOUT_CYCLES = 250000000,
    parameter int unsigned          RELOCK_CYCLES  = 500000000,
    parameter int unsigned          BLINK_CYCLES   = 25000000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [CODE_W-1:0] sw,
    input  logic              enter,
    input  logic              set_code,
    input  logic              lock_req,
    output logic [31:0]       trigger,
    output logic              unlocked,
    output logic              alarm,
    output logic [2:0]        fail_cnt
);

    if (MAX_TRIES < 1 || MAX_TRIES > 7 || LOCKOUT_CYCLES < 1 ||
        RELOCK_CYCLES < 1 || BLINK_CYCLES < 1) begin : g_bad_param
        $error("lock_controller: parameter out of range");
    end

    typedef enum logic [1:0] {
        ST_LOCKED   = 2'd0,
        ST_UNLOCKED = 2'd1,
        ST_LOCKOUT  = 2'd2
    } state_t;

    // Timers count down from N-1 so the exit edge is exactly N cycles after entry.
    localparam logic [31:0] LOCK_LOAD  = 32'(LOCKOUT_CYCLES - 1);
    localparam logic [31:0] BLINK_LOAD = 32'(BLINK_CYCLES - 1);
    // Failure count at which one more wrong entry trips the lockout.
    localparam logic [2:0]  LAST_TRY   = 3'(MAX_TRIES - 1);

    state_t             state_q, state_d;
    logic [CODE_W-1:0]  code_q, code_d;
    logic [2:0]         fail_q, fail_d;
    logic [31:0]        lock_tmr_q, lock_tmr_d;
    logic [31:0]        blink_cnt_q, blink_cnt_d;
    logic               led_q, led_d;
    logic               enter_q;
    logic               ev;
    logic [1:0]         trig_q, trig_d;
    logic               unlocked_q, alarm_q;
`ifdef LOCK_AUTO_RELOCK_EN
    localparam logic [31:0] RELOCK_LOAD = 32'(RELOCK_CYCLES - 1);
    logic [31:0]        relock_q, relock_d;
`endif

    assign ev = enter & ~enter_q;

    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        fail_d      = fail_q;
        lock_tmr_d  = lock_tmr_q;
        blink_cnt_d = blink_cnt_q;
        led_d       = led_q;
`ifdef LOCK_AUTO_RELOCK_EN
        relock_d    = relock_q;
`endif
        case (state_q)
            ST_LOCKED: begin
                if (ev) begin
                    if (sw == code_q) begin
                        state_d = ST_UNLOCKED;
                        fail_d  = 3'd0;
`ifdef LOCK_AUTO_RELOCK_EN
                        relock_d = RELOCK_LOAD;
`endif
                    end else if (fail_q == LAST_TRY) begin
                        state_d     = ST_LOCKOUT;
                        fail_d      = 3'd0;
                        lock_tmr_d  = LOCK_LOAD;
                        blink_cnt_d = BLINK_LOAD;
                        led_d       = 1'b1;
                    end else begin
                        fail_d = fail_q + 3'd1;
                    end
                end
            end
            ST_UNLOCKED: begin
                // lock_req wins over a simultaneous enter, so no code change then.
                // An enter event counts as activity and beats a same-cycle expiry.
                if (lock_req) begin
                    state_d = ST_LOCKED;
                end else if (ev) begin
                    if (set_code) begin
                        code_d = sw;
                    end
`ifdef LOCK_AUTO_RELOCK_EN
                    relock_d = RELOCK_LOAD;
                end else if (relock_q == 32'd0) begin
                    state_d = ST_LOCKED;
                end else begin
                    relock_d = relock_q - 32'd1;
`endif
                end
            end
            ST_LOCKOUT: begin
                // All inputs ignored; only the timer gets us out.
                if (lock_tmr_q == 32'd0) begin
                    state_d = ST_LOCKED;
                end else begin
                    lock_tmr_d = lock_tmr_q - 32'd1;
                    if (blink_cnt_q == 32'd0) begin
                        led_d       = ~led_q;
                        blink_cnt_d = BLINK_LOAD;
                    end else begin
                        blink_cnt_d = blink_cnt_q - 32'd1;
                    end
                end
            end
            default: state_d = ST_LOCKED;
        endcase

        // Outputs are derived from the next state so they register alongside it.
        trig_d = 2'b00;
        if (state_d == ST_UNLOCKED) begin
            trig_d = 2'b11;
        end else if (state_d == ST_LOCKOUT) begin
            trig_d = {1'b0, led_d};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_LOCKED;
            code_q      <= DEFAULT_CODE;
            fail_q      <= 3'd0;
            lock_tmr_q  <= 32'd0;
            blink_cnt_q <= 32'd0;
            led_q       <= 1'b0;
            enter_q     <= 1'b0;
            trig_q      <= 2'b00;
            unlocked_q  <= 1'b0;
            alarm_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            fail_q      <= fail_d;
            lock_tmr_q  <= lock_tmr_d;
            blink_cnt_q <= blink_cnt_d;
            led_q       <= led_d;
            enter_q     <= enter;
            trig_q      <= trig_d;
            unlocked_q  <= (state_d == ST_UNLOCKED);
            alarm_q     <= (state_d == ST_LOCKOUT);
        end
    end

`ifdef LOCK_AUTO_RELOCK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            relock_q <= 32'd0;
        end else begin
            relock_q <= relock_d;
        end
    end
`endif

    assign trigger  = {30'd0, trig_q};
    assign unlocked = unlocked_q;
    assign alarm    = alarm_q;
    assign fail_cnt = fail_q;

endmodule

// File: tb/tb_lock_controller.sv
// Testbench for lock_controller: random + directed stimulus, expected outputs
// from a cycle-counting reference model queued per edge, compared by a monitor.
// Runs with or without LOCK_AUTO_RELOCK_EN defined.
module tb_lock_controller;

    localparam int          MAX_TRIES      = 3;
    localparam int          LOCKOUT_CYCLES = 20;
    localparam int          RELOCK_CYCLES  = 30;
    localparam int          BLINK_CYCLES   = 4;
    localparam logic [9:0]  DEFAULT_CODE   = 10'h2A5;
`ifdef LOCK_AUTO_RELOCK_EN
    localparam int          IDLE_LOOP      = 80;
    localparam int          EXP_IDLE1      = 30;
    localparam int          EXP_IDLE2      = 55;
`else
    localparam int          IDLE_LOOP      = 1000;
    localparam int          EXP_IDLE1      = 1000;
    localparam int          EXP_IDLE2      = 1000;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [9:0]  sw = '0;
    logic        enter = 1'b0;
    logic        set_code = 1'b0;
    logic        lock_req = 1'b0;
    logic [31:0] trigger;
    logic        unlocked;
    logic        alarm;
    logic [2:0]  fail_cnt;

    always #5 clk = ~clk;

    lock_controller #(
        .CODE_W         (10),
        .DEFAULT_CODE   (DEFAULT_CODE),
        .MAX_TRIES      (MAX_TRIES),
        .LOCKOUT_CYCLES (LOCKOUT_CYCLES),
        .RELOCK_CYCLES  (RELOCK_CYCLES),
        .BLINK_CYCLES   (BLINK_CYCLES)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .sw       (sw),
        .enter    (enter),
        .set_code (set_code),
        .lock_req (lock_req),
        .trigger  (trigger),
        .unlocked (unlocked),
        .alarm    (alarm),
        .fail_cnt (fail_cnt)
    );

    typedef struct packed {
        logic [31:0] trigger;
        logic        unlocked;
        logic        alarm;
        logic [2:0]  fail_cnt;
    } obs_t;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic void check(string name, longint got, longint want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    typedef enum int {M_LOCKED, M_OPEN, M_ALARM} mmode_t;
    mmode_t     m_mode;
    logic [9:0] m_code;
    int         m_fails;
    logic       m_enter_q;
    longint     m_cyc = 0;
    longint     m_deadline = 0;
    longint     m_alarm_start = 0;

    function automatic void model_reset();
        m_mode    = M_LOCKED;
        m_code    = DEFAULT_CODE;
        m_fails   = 0;
        m_enter_q = 1'b0;
    endfunction

    function automatic void model_step(logic e, logic [9:0] s, logic sc, logic lr);
        logic ev;
        m_cyc++;
        ev = e && !m_enter_q;
        m_enter_q = e;
        case (m_mode)
            M_LOCKED: begin
                if (ev) begin
                    if (s == m_code) begin
                        m_mode = M_OPEN;
                        m_fails = 0;
                        m_deadline = m_cyc + RELOCK_CYCLES;
                    end else if (m_fails + 1 < MAX_TRIES) begin
                        m_fails++;
                    end else begin
                        m_mode = M_ALARM;
                        m_fails = 0;
                        m_alarm_start = m_cyc;
                    end
                end
            end
            M_OPEN: begin
                if (lr) begin
                    m_mode = M_LOCKED;
                end else if (ev) begin
                    if (sc) m_code = s;
                    m_deadline = m_cyc + RELOCK_CYCLES;
                end
`ifdef LOCK_AUTO_RELOCK_EN
                else if (m_cyc == m_deadline) begin
                    m_mode = M_LOCKED;
                end
`endif
            end
            default: begin
                if (m_cyc == m_alarm_start + LOCKOUT_CYCLES) m_mode = M_LOCKED;
            end
        endcase
    endfunction

    function automatic obs_t model_expect();
        obs_t o;
        o = '0;
        o.fail_cnt = 3'(m_fails);
        if (m_mode == M_OPEN) begin
            o.unlocked = 1'b1;
            o.trigger  = 32'h3;
        end else if (m_mode == M_ALARM) begin
            o.alarm = 1'b1;
            // LED on for the first BLINK_CYCLES cycles, then alternates.
            if (((m_cyc - m_alarm_start) / BLINK_CYCLES) % 2 == 0) o.trigger = 32'h1;
        end
        return o;
    endfunction

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                obs_t e;
                obs_t a;
                e = exp_q.pop_front();
                a = {trigger, unlocked, alarm, fail_cnt};
                check("outputs{trig,unl,alarm,fail}", longint'(a), longint'(e));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(logic rst, logic e, logic [9:0] s, logic sc, logic lr);
        @(negedge clk);
        reset_n  = rst;
        enter    = e;
        sw       = s;
        set_code = sc;
        lock_req = lr;
        if (!rst) model_reset();
        else      model_step(e, s, sc, lr);
        exp_q.push_back(model_expect());
    endtask

    task automatic pulse(logic [9:0] s);
        drive(1'b1, 1'b1, s, 1'b0, 1'b0);
        drive(1'b1, 1'b0, s, 1'b0, 1'b0);
    endtask

    task automatic program_code(logic [9:0] s);
        drive(1'b1, 1'b1, s, 1'b1, 1'b0);
        drive(1'b1, 1'b0, s, 1'b0, 1'b0);
    endtask

    task automatic lock_tick();
        drive(1'b1, 1'b0, sw, 1'b0, 1'b1);
        drive(1'b1, 1'b0, sw, 1'b0, 1'b0);
    endtask

    initial begin
        int cnt;
        model_reset();

        // Reset state
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 10'h000, 1'b0, 1'b0);
        check("reset trigger", trigger, 0);
        check("reset unlocked", unlocked, 0);
        check("reset alarm", alarm, 0);
        check("reset fail_cnt", fail_cnt, 0);
        drive(1'b1, 1'b0, 10'h000, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 10'h000, 1'b0, 1'b0);

        // Default code unlocks; holding enter gives one event
        drive(1'b1, 1'b1, 10'h2A5, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 10'h2A5, 1'b0, 1'b0);
        check("unlock trigger", trigger, 32'h3);
        check("unlock fail_cnt", fail_cnt, 0);
        drive(1'b1, 1'b1, 10'h2A5, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 10'h2A5, 1'b0, 1'b0);
        check("unlock held", unlocked, 1);

        // Three wrong entries -> lockout; correct code ignored during lockout
        lock_tick();
        pulse(10'h000);
        check("fail_cnt after 1 wrong", fail_cnt, 1);
        drive(1'b1, 1'b1, 10'h000, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 10'h000, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 10'h000, 1'b0, 1'b0);
        check("fail_cnt after 2 wrong", fail_cnt, 2);
        drive(1'b1, 1'b1, 10'h000, 1'b0, 1'b0);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, (i % 3 == 1) && (i < 15), 10'h2A5, 1'b0, 1'b0);
            if (alarm) cnt++;
        end
        check("lockout length", cnt, LOCKOUT_CYCLES);
        check("locked after lockout", unlocked, 0);

        // Program new code, lock, old code fails, new code opens
        pulse(10'h2A5);
        program_code(10'h155);
        lock_tick();
        pulse(10'h2A5);
        check("old code fail_cnt", fail_cnt, 1);
        pulse(10'h155);
        check("new code unlocks", unlocked, 1);
        program_code(10'h2A5);

        // Auto-relock timing
        lock_tick();
        drive(1'b1, 1'b1, 10'h2A5, 1'b0, 1'b0);
        cnt = 0;
        for (int i = 0; i < IDLE_LOOP; i++) begin
            drive(1'b1, 1'b0, 10'h2A5, 1'b0, 1'b0);
            if (unlocked) cnt++;
        end
        check("idle unlocked length", cnt, EXP_IDLE1);
        lock_tick();
        drive(1'b1, 1'b1, 10'h2A5, 1'b0, 1'b0);
        cnt = 0;
        for (int i = 0; i < IDLE_LOOP; i++) begin
            drive(1'b1, (i == 24), 10'h2A5, 1'b0, 1'b0);
            if (unlocked) cnt++;
        end
        check("restarted unlocked length", cnt, EXP_IDLE2);

        // lock_req beats a same-cycle set_code enter
        lock_tick();
        pulse(10'h2A5);
        drive(1'b1, 1'b1, 10'h0FF, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 10'h0FF, 1'b0, 1'b0);
        check("lock_req priority", unlocked, 0);
        pulse(10'h2A5);
        check("code unchanged 2A5", unlocked, 1);
        lock_tick();
        pulse(10'h0FF);
        check("0FF rejected", fail_cnt, 1);
        pulse(10'h2A5);

        // Reset mid-lockout reverts code to default
        program_code(10'h155);
        lock_tick();
        pulse(10'h000);
        pulse(10'h000);
        drive(1'b1, 1'b1, 10'h000, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 10'h000, 1'b0, 1'b0);
        check("in lockout before reset", alarm, 1);
        @(negedge clk);
        reset_n = 1'b0;
        enter   = 1'b0;
        model_reset();
        exp_q.push_back(model_expect());
        #1;
        check("async reset trigger", trigger, 0);
        check("async reset alarm", alarm, 0);
        drive(1'b0, 1'b0, 10'h000, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 10'h000, 1'b0, 1'b0);
        pulse(10'h2A5);
        check("default code after reset", unlocked, 1);

        // Random phase
        for (int i = 0; i < 3000; i++) begin
            logic [9:0] s;
            case ($urandom_range(0, 3))
                0:       s = 10'h2A5;
                1:       s = 10'h155;
                default: s = 10'($urandom);
            endcase
            drive(($urandom_range(0, 499) != 0), ($urandom_range(0, 2) == 0), s,
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0));
        end

        drive(1'b1, 1'b0, 10'h000, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
